// File: rtl/ex_pkg.sv
// Shared types for the execute stage: ALU/muldiv opcodes, branch conditions,
// muldiv FSM states and small opcode classification helpers.
package ex_pkg;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU, BR_JUMP
  } br_type_e;

  typedef enum logic [1:0] {
    MD_IDLE, MD_MUL, MD_DIV, MD_DONE
  } md_state_e;

  function automatic logic is_muldiv(alu_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                      OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_mul(alu_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
  endfunction

  // Operand signedness; MUL is treated as signed since its low word is sign-agnostic.
  function automatic logic a_signed(alu_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic b_signed(alu_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/ex_stage_muldiv.sv
// Iterative RV32M multiply/divide: one bit per cycle on operand magnitudes,
// with sign correction and divide special cases applied in the DONE state.
module muldiv_unit
  import ex_pkg::*;
#(
  parameter int WordSize = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                flush_i,
  input  logic                start_i,
  input  logic                advance_i,
  input  alu_op_e             op_i,
  input  logic [WordSize-1:0] a_i,
  input  logic [WordSize-1:0] b_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [WordSize-1:0] result_o
);

  localparam int W    = WordSize;
  localparam int CntW = $clog2(WordSize);
  localparam logic [CntW-1:0] LastCount = CntW'(WordSize - 1);

  md_state_e       state_q, state_d;
  logic [CntW-1:0] count_q, count_d;
  alu_op_e         op_q, op_d;
  logic [W-1:0]    aOrig_q, aOrig_d, bOrig_q, bOrig_d;
  logic [2*W-1:0]  mcand_q, mcand_d, prod_q, prod_d;
  logic [W-1:0]    opnd_q, opnd_d, rem_q, rem_d, quo_q, quo_d;
  logic [W:0]      remShift, trial;
  logic            aNegIn, bNegIn, aNeg, bNeg, divZero;
  logic [W-1:0]    aMagIn, bMagIn, quoFix, remFix;
  logic [2*W-1:0]  prodFix;

  assign aNegIn = a_signed(op_i) & a_i[W-1];
  assign bNegIn = b_signed(op_i) & b_i[W-1];
  assign aMagIn = aNegIn ? -a_i : a_i;
  assign bMagIn = bNegIn ? -b_i : b_i;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= MD_IDLE;
      count_q <= '0;
      op_q    <= OP_ADD;
      aOrig_q <= '0;
      bOrig_q <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
      opnd_q  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      op_q    <= op_d;
      aOrig_q <= aOrig_d;
      bOrig_q <= bOrig_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      opnd_q  <= opnd_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
    end
  end

  // opnd holds the multiplier (shifted right each step) or the fixed divisor.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    op_d     = op_q;
    aOrig_d  = aOrig_q;
    bOrig_d  = bOrig_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    opnd_d   = opnd_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    remShift = {rem_q, quo_q[W-1]};
    trial    = remShift - {1'b0, opnd_q};
    unique case (state_q)
      MD_IDLE: begin
        if (start_i) begin
          op_d    = op_i;
          aOrig_d = a_i;
          bOrig_d = b_i;
          count_d = '0;
          opnd_d  = bMagIn;
          if (is_mul(op_i)) begin
            state_d = MD_MUL;
            mcand_d = {{W{1'b0}}, aMagIn};
            prod_d  = '0;
          end else begin
            state_d = MD_DIV;
            rem_d   = '0;
            quo_d   = aMagIn;
          end
        end
      end
      MD_MUL: begin
        if (opnd_q[0]) prod_d = prod_q + mcand_q;
        mcand_d = mcand_q << 1;
        opnd_d  = opnd_q >> 1;
        count_d = count_q + 1'b1;
        if (count_q == LastCount) state_d = MD_DONE;
      end
      MD_DIV: begin
        if (!trial[W]) begin
          rem_d = trial[W-1:0];
          quo_d = {quo_q[W-2:0], 1'b1};
        end else begin
          rem_d = remShift[W-1:0];
          quo_d = {quo_q[W-2:0], 1'b0};
        end
        count_d = count_q + 1'b1;
        if (count_q == LastCount) state_d = MD_DONE;
      end
      MD_DONE: begin
        if (advance_i) state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
    if (flush_i) begin
      state_d = MD_IDLE;
      count_d = '0;
    end
  end

  // Most-negative / -1 needs no special case: the quotient magnitude 2^(W-1)
  // negates to itself and the remainder is already 0.
  assign aNeg    = a_signed(op_q) & aOrig_q[W-1];
  assign bNeg    = b_signed(op_q) & bOrig_q[W-1];
  assign divZero = (bOrig_q == '0);
  assign prodFix = (aNeg ^ bNeg) ? -prod_q : prod_q;
  assign quoFix  = (aNeg ^ bNeg) ? -quo_q : quo_q;
  assign remFix  = aNeg ? -rem_q : rem_q;

  always_comb begin
    result_o = '0;
    unique case (op_q)
      OP_MUL:                          result_o = prodFix[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:    result_o = prodFix[2*W-1:W];
      OP_DIV, OP_DIVU:                 result_o = divZero ? '1 : quoFix;
      OP_REM, OP_REMU:                 result_o = divZero ? aOrig_q : remFix;
      default:                         result_o = '0;
    endcase
  end

  assign busy_o = (state_q != MD_IDLE);
  assign done_o = (state_q == MD_DONE);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU, branch resolution, iterative muldiv and the
// EX/MEM output register with its stall handshake back to ID/EX.
module ex_stage
  import ex_pkg::*;
#(
  parameter int WordSize = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                flush,
  input  logic                valid_in,
  input  logic [4:0]          alu_op,
  input  logic [2:0]          br_type,
  input  logic [WordSize-1:0] a,
  input  logic [WordSize-1:0] b,
  input  logic [WordSize-1:0] rs2d_in,
  input  logic [WordSize-1:0] pc_in,
  input  logic [WordSize-1:0] branch_addr_in,
  input  logic                branch_taken_in,
  input  logic [4:0]          rdn_in,
  input  logic                mem_ready,
  output logic                busy,
  output logic                valid_out,
  output logic [WordSize-1:0] alu_out,
  output logic [WordSize-1:0] rs2d,
  output logic [4:0]          rdn,
  output logic                mispredict,
  output logic [WordSize-1:0] redirect_pc
);

  localparam int W = WordSize;

  alu_op_e      op;
  br_type_e     brType;
  logic         advance, accept, mdStart, mdBusy, mdDone;
  logic         brActual, mispredictCalc;
  logic [W-1:0] aluResult, mdResult, pcPlus4, redirectCalc;
  logic [4:0]   shamt;

  logic         valid_q, valid_d, mis_q, mis_d;
  logic [W-1:0] aluOut_q, aluOut_d, rs2d_q, rs2d_d, rpc_q, rpc_d;
  logic [W-1:0] mdRs2d_q, mdRs2d_d;
  logic [4:0]   rdn_q, rdn_d, mdRdn_q, mdRdn_d;

  assign op      = alu_op_e'(alu_op);
  assign brType  = br_type_e'(br_type);
  assign shamt   = b[4:0];
  assign advance = mem_ready | ~valid_q;
  assign busy    = mdBusy | ~advance;
  assign accept  = valid_in & ~busy & ~flush;
  assign mdStart = accept & is_muldiv(op);

  muldiv_unit #(.WordSize(WordSize)) u_muldiv (
    .clk       (clk),
    .rstn      (rstn),
    .flush_i   (flush),
    .start_i   (mdStart),
    .advance_i (advance),
    .op_i      (op),
    .a_i       (a),
    .b_i       (b),
    .busy_o    (mdBusy),
    .done_o    (mdDone),
    .result_o  (mdResult)
  );

  always_comb begin
    aluResult = '0;
    unique case (op)
      OP_ADD:  aluResult = a + b;
      OP_SUB:  aluResult = a - b;
      OP_SLL:  aluResult = a << shamt;
      OP_SLT:  aluResult = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: aluResult = {{(W-1){1'b0}}, (a < b)};
      OP_XOR:  aluResult = a ^ b;
      OP_SRL:  aluResult = a >> shamt;
      OP_SRA:  aluResult = $signed(a) >>> shamt;
      OP_OR:   aluResult = a | b;
      OP_AND:  aluResult = a & b;
      default: aluResult = '0;
    endcase
  end

  always_comb begin
    brActual = 1'b0;
    unique case (brType)
      BR_EQ:   brActual = (a == b);
      BR_NE:   brActual = (a != b);
      BR_LT:   brActual = ($signed(a) < $signed(b));
      BR_GE:   brActual = ($signed(a) >= $signed(b));
      BR_LTU:  brActual = (a < b);
      BR_GEU:  brActual = (a >= b);
      BR_JUMP: brActual = 1'b1;
      default: brActual = 1'b0;
    endcase
  end

  assign pcPlus4        = pc_in + W'(4);
  assign mispredictCalc = (brType != BR_NONE) && (brActual != branch_taken_in);
  assign redirectCalc   = (brType == BR_NONE) ? '0 : (brActual ? branch_addr_in : pcPlus4);

  // rdn/rs2d of a muldiv op are captured at accept because ID/EX moves on while it iterates.
  always_comb begin
    valid_d  = valid_q;
    mis_d    = mis_q;
    aluOut_d = aluOut_q;
    rs2d_d   = rs2d_q;
    rdn_d    = rdn_q;
    rpc_d    = rpc_q;
    mdRs2d_d = mdRs2d_q;
    mdRdn_d  = mdRdn_q;
    if (flush) begin
      valid_d = 1'b0;
      mis_d   = 1'b0;
    end else if (advance) begin
      valid_d = 1'b0;
      if (accept && !is_muldiv(op)) begin
        valid_d  = 1'b1;
        aluOut_d = aluResult;
        rs2d_d   = rs2d_in;
        rdn_d    = rdn_in;
        mis_d    = mispredictCalc;
        rpc_d    = redirectCalc;
      end else if (mdDone) begin
        valid_d  = 1'b1;
        aluOut_d = mdResult;
        rs2d_d   = mdRs2d_q;
        rdn_d    = mdRdn_q;
        mis_d    = 1'b0;
        rpc_d    = '0;
      end
    end
    if (mdStart) begin
      mdRs2d_d = rs2d_in;
      mdRdn_d  = rdn_in;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q  <= 1'b0;
      mis_q    <= 1'b0;
      aluOut_q <= '0;
      rs2d_q   <= '0;
      rdn_q    <= '0;
      rpc_q    <= '0;
      mdRs2d_q <= '0;
      mdRdn_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      mis_q    <= mis_d;
      aluOut_q <= aluOut_d;
      rs2d_q   <= rs2d_d;
      rdn_q    <= rdn_d;
      rpc_q    <= rpc_d;
      mdRs2d_q <= mdRs2d_d;
      mdRdn_q  <= mdRdn_d;
    end
  end

  assign valid_out   = valid_q;
  assign mispredict  = mis_q;
  assign alu_out     = aluOut_q;
  assign rs2d        = rs2d_q;
  assign rdn         = rdn_q;
  assign redirect_pc = rpc_q;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: directed vectors push expected EX/MEM entries,
// a negedge monitor pops and compares each entry as downstream consumes it.
module tb_ex_stage;
  import ex_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rstn, flush, valid_in, branch_taken_in, mem_ready;
  logic [4:0]   alu_op, rdn_in;
  logic [2:0]   br_type;
  logic [W-1:0] a, b, rs2d_in, pc_in, branch_addr_in;
  logic         busy, valid_out, mispredict;
  logic [W-1:0] alu_out, rs2d, redirect_pc;
  logic [4:0]   rdn;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic [31:0] st;
    logic [4:0]  rd;
    logic        mis;
    logic [31:0] rpc;
  } exp_t;

  exp_t expQ[$];
  exp_t monEntry;

  ex_stage #(.WordSize(W)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .flush           (flush),
    .valid_in        (valid_in),
    .alu_op          (alu_op),
    .br_type         (br_type),
    .a               (a),
    .b               (b),
    .rs2d_in         (rs2d_in),
    .pc_in           (pc_in),
    .branch_addr_in  (branch_addr_in),
    .branch_taken_in (branch_taken_in),
    .rdn_in          (rdn_in),
    .mem_ready       (mem_ready),
    .busy            (busy),
    .valid_out       (valid_out),
    .alu_out         (alu_out),
    .rs2d            (rs2d),
    .rdn             (rdn),
    .mispredict      (mispredict),
    .redirect_pc     (redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: an entry is consumed at the edge where valid_out & mem_ready.
  always @(negedge clk) begin
    if (rstn && valid_out && mem_ready) begin
      checkOutput("scoreboard has entry", 32'(expQ.size() != 0), 32'd1);
      if (expQ.size() != 0) begin
        monEntry = expQ.pop_front();
        checkOutput({monEntry.name, " alu_out"}, alu_out, monEntry.res);
        checkOutput({monEntry.name, " rs2d"}, rs2d, monEntry.st);
        checkOutput({monEntry.name, " rdn"}, 32'(rdn), 32'(monEntry.rd));
        checkOutput({monEntry.name, " mispredict"}, 32'(mispredict), 32'(monEntry.mis));
        checkOutput({monEntry.name, " redirect_pc"}, redirect_pc, monEntry.rpc);
      end
    end
  end

  task automatic applyStimulus(input string name, input alu_op_e op, input br_type_e br,
                               input logic [31:0] aV, input logic [31:0] bV,
                               input logic [31:0] pcV, input logic [31:0] addrV,
                               input logic takenV, input logic [4:0] rdV, input logic track,
                               input logic [31:0] expRes, input logic expMis,
                               input logic [31:0] expRpc, output int waited);
    exp_t e;
    alu_op          = op;
    br_type         = br;
    a               = aV;
    b               = bV;
    rs2d_in         = ~aV;
    pc_in           = pcV;
    branch_addr_in  = addrV;
    branch_taken_in = takenV;
    rdn_in          = rdV;
    valid_in        = 1'b1;
    if (track) begin
      e.name = name;
      e.res  = expRes;
      e.st   = ~aV;
      e.rd   = rdV;
      e.mis  = expMis;
      e.rpc  = expRpc;
      expQ.push_back(e);
    end
    waited = 0;
    @(negedge clk);
    while (busy && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    checkOutput({name, " accepted within budget"}, 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic aluOp(input string name, input alu_op_e op, input logic [31:0] aV,
                       input logic [31:0] bV, input logic [4:0] rdV, input logic [31:0] expRes);
    int w;
    applyStimulus(name, op, BR_NONE, aV, bV, 32'h1000, 32'h0, 1'b0, rdV, 1'b1,
                  expRes, 1'b0, 32'h0, w);
  endtask

  initial begin
    int waited;
    int n;
    logic busyHeld;
    rstn = 1'b0; flush = 1'b0; valid_in = 1'b0; mem_ready = 1'b1;
    alu_op = '0; br_type = '0; a = '0; b = '0; rs2d_in = '0; pc_in = '0;
    branch_addr_in = '0; branch_taken_in = 1'b0; rdn_in = '0;
    #12;
    checkOutput("reset valid_out", 32'(valid_out), 32'd0);
    checkOutput("reset alu_out", alu_out, 32'd0);
    checkOutput("reset mispredict", 32'(mispredict), 32'd0);
    checkOutput("reset redirect_pc", redirect_pc, 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus("ADD 5+7", OP_ADD, BR_NONE, 32'd5, 32'd7, 32'h1000, 32'h0, 1'b0, 5'd3,
                  1'b1, 32'd12, 1'b0, 32'h0, waited);
    checkOutput("ADD accepted immediately", 32'(waited), 32'd0);
    checkOutput("ADD valid_out next edge", 32'(valid_out), 32'd1);
    checkOutput("ADD busy stays low", 32'(busy), 32'd0);

    aluOp("SUB 3-5", OP_SUB, 32'd3, 32'd5, 5'd4, 32'hFFFF_FFFE);
    aluOp("SLL 1<<1", OP_SLL, 32'd1, 32'h21, 5'd5, 32'd2);
    aluOp("SRA", OP_SRA, 32'h8000_0000, 32'h24, 5'd6, 32'hF800_0000);
    aluOp("SLT -1<1", OP_SLT, 32'hFFFF_FFFF, 32'd1, 5'd7, 32'd1);
    aluOp("SLTU 1<max", OP_SLTU, 32'd1, 32'hFFFF_FFFF, 5'd8, 32'd1);

    applyStimulus("MULHU", OP_MULHU, BR_NONE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1000, 32'h0,
                  1'b0, 5'd9, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'h0, waited);
    n = 0;
    busyHeld = 1'b1;
    while (n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (valid_out) break;
      if (!busy) busyHeld = 1'b0;
    end
    checkOutput("MULHU latency", 32'(n), 32'd33);
    checkOutput("MULHU busy held", 32'(busyHeld), 32'd1);
    checkOutput("MULHU busy after done", 32'(busy), 32'd0);

    aluOp("MUL", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 32'd1);
    aluOp("MULH -1*-1", OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 32'd0);
    aluOp("DIV 7/0", OP_DIV, 32'd7, 32'd0, 5'd12, 32'hFFFF_FFFF);
    aluOp("REM 7/0", OP_REM, 32'd7, 32'd0, 5'd13, 32'd7);
    aluOp("DIV ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000);
    aluOp("REM ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0);
    aluOp("DIV -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd16, 32'hFFFF_FFFD);
    aluOp("REM -7/2", OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd17, 32'hFFFF_FFFF);
    aluOp("DIVU 100/7", OP_DIVU, 32'd100, 32'd7, 5'd18, 32'd14);
    aluOp("REMU 100/7", OP_REMU, 32'd100, 32'd7, 5'd19, 32'd2);

    applyStimulus("BEQ", OP_SUB, BR_EQ, 32'd3, 32'd3, 32'h40, 32'h100, 1'b0, 5'd0, 1'b1,
                  32'd0, 1'b1, 32'h100, waited);
    applyStimulus("BLT", OP_ADD, BR_LT, 32'hFFFF_FFFF, 32'd1, 32'h80, 32'h200, 1'b1, 5'd0, 1'b1,
                  32'd0, 1'b0, 32'h200, waited);
    applyStimulus("BNE wrap", OP_XOR, BR_NE, 32'd5, 32'd5, 32'hFFFF_FFFC, 32'h300, 1'b1, 5'd0,
                  1'b1, 32'd0, 1'b1, 32'h0, waited);
    applyStimulus("JUMP", OP_ADD, BR_JUMP, 32'h500, 32'd4, 32'h500, 32'h800, 1'b0, 5'd1, 1'b1,
                  32'h504, 1'b1, 32'h800, waited);
    applyStimulus("BGEU", OP_SLTU, BR_GEU, 32'd1, 32'hFFFF_FFFF, 32'h600, 32'h900, 1'b0, 5'd0,
                  1'b1, 32'd1, 1'b0, 32'h604, waited);

    repeat (2) @(posedge clk);
    #1;
    mem_ready = 1'b0;
    aluOp("ADD stalled", OP_ADD, 32'd10, 32'd20, 5'd20, 32'd30);
    for (int i = 0; i < 3; i++) begin
      checkOutput("stall valid_out held", 32'(valid_out), 32'd1);
      checkOutput("stall busy", 32'(busy), 32'd1);
      checkOutput("stall alu_out held", alu_out, 32'd30);
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b1;
    applyStimulus("ADD after stall", OP_ADD, BR_NONE, 32'd1, 32'd2, 32'h1000, 32'h0, 1'b0,
                  5'd21, 1'b1, 32'd3, 1'b0, 32'h0, waited);
    checkOutput("accept on release edge", 32'(waited), 32'd0);

    applyStimulus("DIV flushed", OP_DIV, BR_NONE, 32'd100, 32'd3, 32'h1000, 32'h0, 1'b0,
                  5'd22, 1'b0, 32'd0, 1'b0, 32'h0, waited);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checkOutput("flush valid_out", 32'(valid_out), 32'd0);
    checkOutput("flush busy", 32'(busy), 32'd0);
    applyStimulus("ADD after flush", OP_ADD, BR_NONE, 32'd4, 32'd4, 32'h1000, 32'h0, 1'b0,
                  5'd23, 1'b1, 32'd8, 1'b0, 32'h0, waited);
    checkOutput("ADD after flush accepted", 32'(waited), 32'd0);

    applyStimulus("MUL reset", OP_MUL, BR_NONE, 32'd3, 32'd4, 32'h1000, 32'h0, 1'b0,
                  5'd24, 1'b0, 32'd0, 1'b0, 32'h0, waited);
    repeat (3) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("async reset valid_out", 32'(valid_out), 32'd0);
    checkOutput("async reset busy", 32'(busy), 32'd0);
    checkOutput("async reset alu_out", alu_out, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    aluOp("ADD wrap", OP_ADD, 32'hFFFF_FFFF, 32'd1, 5'd25, 32'd0);

    n = 0;
    while (expQ.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage directly downstream of the ID/EX pipeline register.
- Consumes the ID/EX register outputs: operands a/b, rs2 data, pc, branch target, predicted-taken flag and destination register.
- Computes single-cycle ALU results, runs RV32M multiply/divide as an iterative multi-cycle operation, and resolves branches.
- Holds all results in an EX/MEM output register, with a busy/stall handshake back to ID/EX.

Parameters:
WordSize, 32, datapath width in bits.

Ports:
clk  in  1  clock
rstn  in  1  reset; asynchronous, active-low
flush  in  1  synchronous kill of the in-flight op and the output register
valid_in  in  1  ID/EX holds a valid instruction
alu_op  in  5  operation code (ex_pkg::alu_op_e)
br_type  in  3  branch condition (ex_pkg::br_type_e)
a  in  WordSize  operand A from ID/EX
b  in  WordSize  operand B from ID/EX
rs2d_in  in  WordSize  store data from ID/EX
pc_in  in  WordSize  instruction pc
branch_addr_in  in  WordSize  computed branch/jump target
branch_taken_in  in  1  predicted-taken flag
rdn_in  in  5  destination register
mem_ready  in  1  downstream accepts the EX/MEM register this cycle
busy  out  1  stall to ID/EX: hold inputs
valid_out  out  1  EX/MEM entry valid
alu_out  out  WordSize  result
rs2d  out  WordSize  registered store data
rdn  out  5  registered destination register
mispredict  out  1  resolved direction differs from prediction
redirect_pc  out  WordSize  correct next pc when mispredict=1

Behaviour:
- Reset: every output is 0, FSM goes to IDLE, the iteration counter is 0.
- Output register advance: advance = mem_ready | ~valid_out. When advance=0, all outputs hold and busy=1.
- Accept: an op is accepted at an edge where valid_in & ~busy & ~flush.
- ALU ops (ADD SUB SLL SLT SLTU XOR SRL SRA OR AND):
  - Result is written to the output register at the accepting edge; valid_out=1 after that edge (1-cycle latency).
  - Shift amount is b[4:0].
- FSM states: IDLE, MUL, DIV, DONE.
- Accepting a MUL/MULH/MULHSU/MULHU op: IDLE->MUL, latch operands, count=0.
  - Shift-add, one bit per cycle, over a 2*WordSize-bit product.
  - Signed variants sign-correct the operands/product per RV32M.
- Accepting a DIV/DIVU/REM/REMU op: IDLE->DIV. Restoring division, one bit per cycle on magnitudes; signs are fixed at completion.
- MUL/DIV exit to DONE when count reaches WordSize-1. DONE writes the output register if advance, then goes to IDLE; otherwise it stays in DONE.
- Latency: a muldiv op accepted at edge E0 is written at edge E0+WordSize+1, i.e. 33 cycles for the default width.
- busy during muldiv: 1 in MUL, DIV and DONE; combinationally 0 in IDLE when advance=1.
- Special cases are resolved at completion, with the same latency:
  - Divide by zero: DIV/DIVU give all-ones; REM/REMU give the dividend.
  - Signed overflow (most-negative / -1): DIV gives most-negative; REM gives 0.
- Branch resolution uses a vs b. br_type values:
  - NONE: never a branch.
  - EQ, NE, LT, GE, LTU, GEU: compare a vs b.
  - JUMP: always taken.
- For br_type≠NONE: actual = cond(a, b).
  - mispredict = actual ≠ branch_taken_in.
  - redirect_pc = actual ? branch_addr_in : pc_in+4.
- For br_type=NONE: mispredict=0, redirect_pc=0.
- mispredict and redirect_pc are registered with the other outputs, so they are valid only when valid_out=1.
- Flush: at the edge, FSM->IDLE, count=0, valid_out=0, mispredict=0. A simultaneous accept is discarded; flush wins over completion and over mem_ready.
- Arithmetic: all arithmetic wraps mod 2^WordSize.
- pc+4 wrap-around: pc_in+4 wraps at 2^WordSize (0xFFFFFFFC -> 0x00000000).
- Reset mid-operation: reset asserted during MUL/DIV forces the reset values immediately (asynchronous).

Decomposition:
- ex_pkg holds:
  - alu_op_e (5-bit: ADD..AND, MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
  - br_type_e (3-bit: NONE, EQ, NE, LT, GE, LTU, GEU, JUMP).
  - the is_muldiv(op) function.
- Sub-module muldiv_unit holds the iterative FSM, counter and special-case fixup.
  - Interface: start/op/a/b in; done/result out.
  - ex_stage keeps the ALU, branch compare, output register and handshake.

Test Plan:
- ADD a=5, b=7, valid_in=1 -> next edge alu_out=12, valid_out=1, busy stays 0.
- MULHU a=b=0xFFFFFFFF -> busy=1 for 33 cycles, then alu_out=0xFFFFFFFE, valid_out=1. Also MUL with the same operands -> 0x00000001.
- DIV a=7, b=0 -> 0xFFFFFFFF; REM a=7, b=0 -> 7; DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM on the same operands -> 0.
- BEQ a=b=3 with branch_taken_in=0, branch_addr_in=0x100, pc_in=0x40 -> mispredict=1, redirect_pc=0x100. BLT a=-1, b=1 predicted taken -> mispredict=0.
- ADD completes with mem_ready=0 for 3 cycles -> outputs hold, busy=1; mem_ready=1 -> next op is accepted on that edge.
- flush asserted 10 cycles into a DIV -> next edge valid_out=0, FSM idle, busy=0. An ADD accepted on the following edge completes normally.
